// File: rtl/calc_pkg.sv
// calc_pkg: shared state encoding and golden arithmetic
// for the calculator-core initiator.
package calc_pkg;

  localparam int OP_EXTRA = 4;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ISSUE   = 2'd1;
  localparam logic [1:0] ST_WAIT    = 2'd2;
  localparam logic [1:0] ST_DELIVER = 2'd3;

  localparam int DEF_WIDTH    = 32;
  localparam int DEF_OP_WIDTH = DEF_WIDTH + OP_EXTRA;

  function automatic logic [DEF_OP_WIDTH-1:0] calc_golden(
    input logic [DEF_WIDTH-1:0] a,
    input logic [DEF_WIDTH-1:0] b
  );
    logic [DEF_OP_WIDTH-1:0] ax;
    logic [DEF_OP_WIDTH-1:0] bx;
    ax = DEF_OP_WIDTH'(a);
    bx = DEF_OP_WIDTH'(b);
    return (((ax >> 1) + bx) << 3)
         + ((ax - (bx >> 1)) << 2);
  endfunction

endpackage

// File: rtl/calc_golden_model.sv
// calc_golden_model: combinational reference value
// Y = ((A>>1)+B)*8 + (A-(B>>1))*4 at OP_WIDTH bits.
module calc_golden_model
  import calc_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int OP_WIDTH = WIDTH + OP_EXTRA
) (
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  output logic [OP_WIDTH-1:0] y
);

  logic [OP_WIDTH-1:0] ax;
  logic [OP_WIDTH-1:0] bx;
  logic [OP_WIDTH-1:0] sum_t;
  logic [OP_WIDTH-1:0] dif_t;

  assign ax    = OP_WIDTH'(a);
  assign bx    = OP_WIDTH'(b);
  assign sum_t = (ax >> 1) + bx;
  // wraps modulo 2^OP_WIDTH when B/2 > A
  assign dif_t = ax - (bx >> 1);
  assign y     = (sum_t << 3) + (dif_t << 2);

endmodule

// File: rtl/calc_initiator.sv
// calc_initiator: issues operand pairs to the calculator
// core, self-checks results and guards with a timeout.
module calc_initiator
  import calc_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int OP_WIDTH  = WIDTH + OP_EXTRA,
  parameter int TIMEOUT   = 64,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  output logic                 core_start,
  output logic [WIDTH-1:0]     core_a,
  output logic [WIDTH-1:0]     core_b,
  input  logic                 core_done,
  input  logic [OP_WIDTH-1:0]  core_result,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OP_WIDTH-1:0]  out_result,
  output logic                 out_mismatch,
  output logic                 out_timeout,
  output logic [CNT_WIDTH-1:0] err_count,
  output logic                 busy
);

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  logic [1:0]          state;
  logic [TW-1:0]       tcnt;
  logic [OP_WIDTH-1:0] golden_c;
  logic [OP_WIDTH-1:0] golden_q;
  logic                res_bad;

  calc_golden_model #(
    .WIDTH   (WIDTH),
    .OP_WIDTH(OP_WIDTH)
  ) u_golden (
    .a(core_a),
    .b(core_b),
    .y(golden_c)
  );

  assign busy    = (state != ST_IDLE);
  assign res_bad = (core_result != golden_q);

  function automatic logic [CNT_WIDTH-1:0] sat_inc(
    input logic [CNT_WIDTH-1:0] v
  );
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      in_ready     <= 1'b0;
      core_start   <= 1'b0;
      core_a       <= '0;
      core_b       <= '0;
      golden_q     <= '0;
      tcnt         <= '0;
      out_valid    <= 1'b0;
      out_result   <= '0;
      out_mismatch <= 1'b0;
      out_timeout  <= 1'b0;
      err_count    <= '0;
    end else begin
      core_start <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            core_a     <= in_a;
            core_b     <= in_b;
            core_start <= 1'b1;
            in_ready   <= 1'b0;
            state      <= ST_ISSUE;
          end else begin
            in_ready <= 1'b1;
          end
        end
        ST_ISSUE: begin
          golden_q <= golden_c;
          tcnt     <= '0;
          state    <= ST_WAIT;
        end
        ST_WAIT: begin
          // a done on the last allowed cycle still counts
          if (core_done) begin
            out_result   <= core_result;
            out_mismatch <= res_bad;
            out_timeout  <= 1'b0;
            out_valid    <= 1'b1;
            state        <= ST_DELIVER;
            if (res_bad) err_count <= sat_inc(err_count);
          end else if (tcnt == T_LAST) begin
            out_result   <= '0;
            out_mismatch <= 1'b0;
            out_timeout  <= 1'b1;
            out_valid    <= 1'b1;
            state        <= ST_DELIVER;
            err_count    <= sat_inc(err_count);
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        ST_DELIVER: begin
          if (out_ready) begin
            out_valid    <= 1'b0;
            out_mismatch <= 1'b0;
            out_timeout  <= 1'b0;
            in_ready     <= 1'b1;
            state        <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_initiator.sv
// tb_calc_initiator: vector table, random and corner-case
// checks against a plain-arithmetic reference model.
module tb_calc_initiator;

  localparam int W  = 32;
  localparam int OW = 36;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_a = '0;
  logic [W-1:0]  in_b = '0;
  logic          core_start;
  logic [W-1:0]  core_a;
  logic [W-1:0]  core_b;
  logic          core_done = 1'b0;
  logic [OW-1:0] core_result = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [OW-1:0] out_result;
  logic          out_mismatch;
  logic          out_timeout;
  logic [7:0]    err_count;
  logic          busy;

  int checks = 0;
  int passed = 0;
  int exp_err = 0;

  calc_initiator #(
    .WIDTH(W), .OP_WIDTH(OW), .TIMEOUT(TO), .CNT_WIDTH(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b),
    .core_start(core_start), .core_a(core_a), .core_b(core_b),
    .core_done(core_done), .core_result(core_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_mismatch(out_mismatch),
    .out_timeout(out_timeout), .err_count(err_count), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  function automatic void chk(string nm, longint unsigned act,
                              longint unsigned exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endfunction

  // reference: plain 64-bit arithmetic reduced modulo 2^36
  function automatic logic [OW-1:0] gold(longint unsigned a,
                                         longint unsigned b);
    longint unsigned m, s, d;
    m = (64'd1 << OW) - 1;
    s = (a / 2) + b;
    d = (a - (b / 2)) & m;
    return OW'((s * 8 + d * 4) & m);
  endfunction

  task automatic txn(input logic [W-1:0] a, input logic [W-1:0] b,
                     input int lat, input logic [OW-1:0] cres,
                     input int hold, input bit spur,
                     input logic [OW-1:0] eres,
                     input bit emm, input bit eto);
    int n;
    bit stable;
    logic [OW-1:0] r0;
    logic m0, t0;
    n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready", in_ready, 1);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    @(negedge clk);
    in_valid = 1'b0;
    chk("start", core_start, 1);
    chk("core_a", core_a, a);
    chk("core_b", core_b, b);
    chk("in_ready_busy", in_ready, 0);
    if (lat > 0) begin
      repeat (lat) @(negedge clk);
      chk("start_pulse", core_start, 0);
      chk("early_valid", out_valid, 0);
      chk("core_b_hold", core_b, b);
      core_done = 1'b1;
      core_result = cres;
      @(negedge clk);
      core_done = 1'b0;
      chk("done_latency", out_valid, 1);
    end else begin
      n = 0;
      while (out_valid !== 1'b1 && n < TO + 10) begin
        @(negedge clk);
        n++;
      end
      chk("timeout_cycles", n, TO + 1);
    end
    chk("result", out_result, eres);
    chk("mismatch", out_mismatch, emm);
    chk("timeout", out_timeout, eto);
    if (emm || eto) exp_err = (exp_err == 255) ? 255 : exp_err + 1;
    chk("err_count", err_count, exp_err);
    r0 = out_result;
    m0 = out_mismatch;
    t0 = out_timeout;
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      if (spur) begin
        core_done = i[0];
        core_result = OW'($urandom);
      end
      @(negedge clk);
      if (out_valid !== 1'b1 || out_result !== r0 ||
          out_mismatch !== m0 || out_timeout !== t0 ||
          in_ready !== 1'b0 || err_count !== 8'(exp_err))
        stable = 1'b0;
    end
    core_done = 1'b0;
    if (hold > 0) chk("stall_stable", stable, 1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("valid_fall", out_valid, 0);
    chk("flags_clear", {out_mismatch, out_timeout}, 0);
    chk("in_ready_back", in_ready, 1);
  endtask

  typedef struct {
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    int            lat;
    logic [OW-1:0] cres;
    logic [OW-1:0] eres;
    bit            emm;
    bit            eto;
  } vec_t;

  vec_t tbl[6];

  initial begin
    logic [W-1:0] ra, rb;
    logic [OW-1:0] g, cr;
    int lat, mode;
    bit stable;

    tbl[0] = '{32'd10, 32'd4, 9, 36'd104, 36'd104, 1'b0, 1'b0};
    tbl[1] = '{32'd0, 32'd2, 3, 36'd12, 36'd12, 1'b0, 1'b0};
    tbl[2] = '{32'd0, 32'd2, 3, 36'd13, 36'd13, 1'b1, 1'b0};
    tbl[3] = '{32'd1, 32'd3, 0, 36'd0, 36'd0, 1'b0, 1'b1};
    tbl[4] = '{32'd1, 32'd3, TO, 36'd24, 36'd24, 1'b0, 1'b0};
    tbl[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1,
               36'hDFFFFFFF0, 36'hDFFFFFFF0, 1'b0, 1'b0};

    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_outs", {out_valid, out_mismatch, out_timeout, core_start}, 0);
    chk("rst_result", out_result, 0);
    chk("rst_err", err_count, 0);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("idle_in_ready", in_ready, 1);

    foreach (tbl[i])
      txn(tbl[i].a, tbl[i].b, tbl[i].lat, tbl[i].cres, 0, 1'b0,
          tbl[i].eres, tbl[i].emm, tbl[i].eto);

    // long downstream stall with spurious done pulses
    txn(32'd2, 32'd1, 5, 36'd24, 20, 1'b1, 36'd24, 1'b0, 1'b0);

    // spurious done while idle
    stable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      core_done = i[0];
      core_result = OW'($urandom);
      @(negedge clk);
      if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0 ||
          err_count !== 8'(exp_err))
        stable = 1'b0;
    end
    core_done = 1'b0;
    chk("idle_spurious", stable, 1);

    // reset in the middle of WAIT
    in_valid = 1'b1;
    in_a = 32'd5;
    in_b = 32'd7;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("busy_wait", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_outs", {out_valid, out_mismatch, out_timeout, in_ready}, 0);
    chk("mid_rst_core", {core_a, core_b}, 0);
    chk("mid_rst_err", err_count, 0);
    exp_err = 0;
    @(negedge clk);
    rst_n = 1'b1;
    txn(32'd0, 32'd0, 4, 36'd0, 0, 1'b0, 36'd0, 1'b0, 1'b0);

    // randomized transactions against the reference model
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 4 == 0) ra = W'($urandom_range(0, 7));
      mode = $urandom_range(0, 9);
      g = gold(ra, rb);
      cr = g;
      if (mode == 1 || mode == 2) cr = g ^ OW'(64'd1 << $urandom_range(0, OW - 1));
      if (mode == 0) lat = 0;
      else if ($urandom_range(0, 7) == 0) lat = TO;
      else lat = $urandom_range(1, 12);
      txn(ra, rb, lat, cr, $urandom_range(0, 3), 1'b0,
          (lat == 0) ? '0 : cr,
          (lat != 0) && (cr != gold(ra, rb)), lat == 0);
    end

    // drive the error counter into saturation
    for (int i = 0; i < 300; i++) begin
      ra = $urandom;
      rb = $urandom;
      g = gold(ra, rb);
      cr = g ^ OW'(64'd1 << $urandom_range(0, OW - 1));
      txn(ra, rb, 1, cr, 0, 1'b0, cr, 1'b1, 1'b0);
    end
    chk("err_saturated", err_count, 255);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
